// File: rtl/gnrl_dconv_boxcar.sv
// Boxcar decimating down-converter.
// Pipeline: DC offset removal with positive clamp, fs/4 quadrature mix (or
// bypass), then an integrate-and-dump window of dec_factor samples.
module gnrl_dconv_boxcar #(
    parameter int ADC_PHYS_WIDTH = 14,
    parameter int DEC_WIDTH      = 8,
    localparam int OUT_WIDTH     = ADC_PHYS_WIDTH + 1 + DEC_WIDTH
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [ADC_PHYS_WIDTH-1:0]   adc_data_in,
    input  logic signed [ADC_PHYS_WIDTH:0] adc_dcval_subtractor,
    input  logic [DEC_WIDTH-1:0]        dec_factor,
    input  logic                        mix_mode,
    input  logic                        conv_en,
    output logic signed [OUT_WIDTH-1:0] data_i,
    output logic signed [OUT_WIDTH-1:0] data_q,
    output logic                        data_valid,
    output logic                        sat_flag
);

    localparam int W = ADC_PHYS_WIDTH;
    localparam int D = DEC_WIDTH;
    localparam logic signed [W+1:0] MAX_POS  = {2'b00, {W{1'b1}}};
    localparam logic signed [W:0]   X_CLAMP  = {1'b0, {W{1'b1}}};

    // Stage 1 state
    logic signed [W+1:0] diff;
    logic signed [W:0]   x_clamped;
    logic                sat_now;
    logic signed [W:0]   x1;
    logic                v1;
    logic                en_d;
    logic [1:0]          phase;

    // Stage 2 state
    logic signed [W:0]   mix_i;
    logic signed [W:0]   mix_q;
    logic signed [W:0]   i2;
    logic signed [W:0]   q2;
    logic                v2;

    // Stage 3 state
    logic signed [OUT_WIDTH-1:0] ext_i;
    logic signed [OUT_WIDTH-1:0] ext_q;
    logic signed [OUT_WIDTH-1:0] sum_i;
    logic signed [OUT_WIDTH-1:0] sum_q;
    logic signed [OUT_WIDTH-1:0] acc_i;
    logic signed [OUT_WIDTH-1:0] acc_q;
    logic [D-1:0]                count;
    logic [D-1:0]                n_lat;
    logic [D-1:0]                dec_eff;
    logic [D-1:0]                n_eff;
    logic                        first;
    logic                        last;

    // Offset removal in W+2 bits; only the positive side can exceed the W+1 range
    always_comb begin
        diff      = $signed({2'b00, adc_data_in}) - $signed({adc_dcval_subtractor[W], adc_dcval_subtractor});
        sat_now   = (diff > MAX_POS);
        x_clamped = sat_now ? X_CLAMP : diff[W:0];
    end

    // Stage 1 register, sample-valid, and sticky saturation flag cleared on a conv_en rise
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x1       <= '0;
            v1       <= 1'b0;
            en_d     <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            v1   <= conv_en;
            en_d <= conv_en;
            if (conv_en) begin
                x1 <= x_clamped;
            end
            if (conv_en && sat_now) begin
                sat_flag <= 1'b1;
            end else if (conv_en && !en_d) begin
                sat_flag <= 1'b0;
            end
        end
    end

    // Mixer phase walks with each valid stage-1 sample and restarts whenever the stream breaks
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase <= 2'd0;
        end else if (v1) begin
            phase <= phase + 2'd1;
        end else begin
            phase <= 2'd0;
        end
    end

    // fs/4 rotation: multiply by cos/-sin of phase*90 degrees, or pass straight through in bypass
    always_comb begin
        mix_i = '0;
        mix_q = '0;
        if (mix_mode) begin
            mix_i = x1;
        end else begin
            case (phase)
                2'd0:    mix_i = x1;
                2'd1:    mix_q = -x1;
                2'd2:    mix_i = -x1;
                default: mix_q = x1;
            endcase
        end
    end

    // Stage 2 register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            i2 <= '0;
            q2 <= '0;
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                i2 <= mix_i;
                q2 <= mix_q;
            end
        end
    end

    // Window bookkeeping: length latched on the first sample of each window, zero means one
    always_comb begin
        ext_i   = {{D{i2[W]}}, i2};
        ext_q   = {{D{q2[W]}}, q2};
        sum_i   = acc_i + ext_i;
        sum_q   = acc_q + ext_q;
        first   = (count == '0);
        dec_eff = (dec_factor == '0) ? D'(1) : dec_factor;
        n_eff   = first ? dec_eff : n_lat;
        last    = ((count + D'(1)) == n_eff);
    end

    // Integrate-and-dump; a gap in the stream discards the partial window
    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_i      <= '0;
            acc_q      <= '0;
            count      <= '0;
            n_lat      <= '0;
            data_i     <= '0;
            data_q     <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (!v2) begin
                acc_i <= '0;
                acc_q <= '0;
                count <= '0;
            end else begin
                if (first) begin
                    n_lat <= dec_eff;
                end
                if (last) begin
                    data_i     <= sum_i;
                    data_q     <= sum_q;
                    data_valid <= 1'b1;
                    acc_i      <= '0;
                    acc_q      <= '0;
                    count      <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    count <= count + D'(1);
                end
            end
        end
    end

endmodule

// File: doc/gnrl_dconv_boxcar.md
GNRL_DCONV_BOXCAR -- requirements
Module: GNRL_dconv_boxcar

Interface
REQ-001 SHALL have parameter ADC_PHYS_WIDTH, default 14, ADC sample width W.
REQ-002 SHALL have parameter DEC_WIDTH, default 8, width D of decimation factor; max window 2^D-1 samples.
REQ-003 SHALL have derived localparam OUT_WIDTH = W+1+D, output word width.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port adc_data_in  input  W  unsigned ADC sample.
REQ-007 SHALL have port adc_dcval_subtractor  input  W+1  signed DC offset to remove.
REQ-008 SHALL have port dec_factor  input  D  samples per output window, unsigned; 0 treated as 1.
REQ-009 SHALL have port mix_mode  input  1  0 = fs/4 quadrature mix, 1 = bypass (I = x, Q = 0).
REQ-010 SHALL have port conv_en  input  1  sample-accept enable, one sample per high cycle.
REQ-011 SHALL have port data_i  output  OUT_WIDTH  signed in-phase window sum.
REQ-012 SHALL have port data_q  output  OUT_WIDTH  signed quadrature window sum.
REQ-013 SHALL have port data_valid  output  1  one-cycle strobe, data_i/data_q updated.
REQ-014 SHALL have port sat_flag  output  1  sticky flag, DC-subtract saturated.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 DC subtract, S2 mix, S3 accumulate/dump; conv_en travels as per-stage valid.
REQ-016 S1 SHALL compute x = {0,adc_data_in} - adc_dcval_subtractor in W+2 bits, clamp to signed W+1 range, and register it.
REQ-017 S1 SHALL clamp positive overflow to 2^W-1 and set sat_flag; negative overflow cannot occur (min -(2^W-1)), so no negative clamp.
REQ-018 Phase counter (2 bits) SHALL advance on each S1-valid sample and SHALL reset to 0 on any cycle S1-valid is low.
REQ-019 S2 in mix_mode 0 SHALL output by phase 0/1/2/3: I = x,0,-x,0; Q = 0,-x,0,x; negation never overflows.
REQ-020 S2 in mix_mode 1 SHALL output I = x, Q = 0 on every phase.
REQ-021 S3 SHALL sign-extend S2 outputs to OUT_WIDTH and accumulate I and Q in parallel; no accumulator overflow possible by width.
REQ-022 Window length N SHALL latch from dec_factor (0 -> 1) when the first sample of a window enters S3; mid-window changes take effect next window.
REQ-023 On the Nth sample of a window S3 SHALL load data_i/data_q with accumulator+sample, pulse data_valid for 1 cycle, and restart accumulation from 0 on the next sample.
REQ-024 Latency: sample accepted with conv_en high at cycle k, window completes -> data_valid high at cycle k+3.
REQ-025 With N=1 and continuous conv_en, data_valid SHALL be high every cycle.
REQ-026 When S2-valid is low, S3 SHALL clear accumulator and window count, discard the partial window, and not assert data_valid.
REQ-027 data_i/data_q SHALL hold their last value between strobes and across conv_en low.
REQ-028 sat_flag SHALL clear on the cycle conv_en rises (0->1) unless that same cycle's S1 result saturates.
REQ-029 mix_mode SHALL be sampled per sample at S2; switching mid-window is allowed, no flush.

Reset
REQ-030 RESET high SHALL zero data_i, data_q, data_valid, sat_flag, accumulators, phase, window count and all pipeline valids on the next edge.
REQ-031 RESET SHALL override conv_en; in-flight samples SHALL be dropped, and the first sample after RESET low SHALL use phase 0.

Verification
REQ-032 Reset: RESET high 2 cycles mid-window with N=4 -> all outputs 0, no data_valid, next window full 4 samples.
REQ-033 N=1, mix 0, adc 10000, dcval 9400, conv_en high -> first data_valid 3 cycles later; I = 600,0,-600,0..., Q = 0,-600,0,600..., valid every cycle.
REQ-034 N=4, mix 0, adc cycling 10000,9400,8800,9400, dcval 9400 -> valid every 4th cycle, I = 1200, Q = 0.
REQ-035 Saturation: adc 16383, dcval -16384 -> x = 16383, sat_flag 1 and held; conv_en 0->1 with dcval 0 -> sat_flag 0.
REQ-036 N=8, conv_en dropped after 5 samples -> no data_valid, outputs hold; re-enabled -> phase 0, first valid after 8 samples +3 cycles.
REQ-037 dec_factor 4 -> 2 mid-window, mix 1, x = 100 -> current window sum 400, following windows 200; dec_factor 0 -> sum 100 every cycle.
